// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational reads, two prioritised writes,
// optional write-to-read bypass, post-reset clear sweep and a sequential dump port.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  input  logic                   wr0_en,
  input  logic [AW-1:0]          wr0_addr,
  input  logic [WIDTH-1:0]       wr0_data,
  input  logic                   wr1_en,
  input  logic [AW-1:0]          wr1_addr,
  input  logic [WIDTH-1:0]       wr1_data,
  output logic                   ready,
  input  logic                   dump_req,
  output logic                   dump_valid,
  output logic [AW-1:0]          dump_idx,
  output logic [WIDTH-1:0]       dump_data,
  output logic                   dump_done
);

  typedef enum logic {CLEAR, RUN} state_t;
  typedef enum logic {D_IDLE, D_ACTIVE} dstate_t;

  logic [WIDTH-1:0] mem [DEPTH];

  state_t        state_reg, state_next;
  logic [AW-1:0] clr_idx_reg, clr_idx_next;
  logic          clr_we;
  logic          run;
  logic          wr0_ok, wr1_ok;

  // Main FSM: sweep every entry to zero, then serve accesses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= CLEAR;
      clr_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    clr_we       = 1'b0;
    if (state_reg == CLEAR) begin
      clr_we       = 1'b1;
      clr_idx_next = clr_idx_reg + AW'(1);
      if (clr_idx_reg == AW'(DEPTH - 1))
        state_next = RUN;
    end
  end

  assign run    = (state_reg == RUN);
  assign ready  = run;
  assign wr0_ok = run && wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
  assign wr1_ok = run && wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (clr_we)
        mem[clr_idx_reg] <= '0;
      if (wr0_ok)
        mem[wr0_addr] <= wr0_data;
      if (wr1_ok)
        mem[wr1_addr] <= wr1_data;
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] word;
    assign addr = rd_addr[gi*AW +: AW];
    always_comb begin
      word = mem[addr];
      if ((BYPASS != 0) && wr0_ok && (wr0_addr == addr))
        word = wr0_data;
      if ((BYPASS != 0) && wr1_ok && (wr1_addr == addr))
        word = wr1_data;
      if (((ZERO_REG != 0) && (addr == '0)) || !run)
        word = '0;
    end
    assign rd_data[gi*WIDTH +: WIDTH] = word;
  end

  dstate_t          dstate_reg, dstate_next;
  logic [AW-1:0]    dcnt_reg, dcnt_next;
  logic             dump_valid_reg, dump_valid_next;
  logic             dump_done_reg, dump_done_next;
  logic [AW-1:0]    dump_idx_reg, dump_idx_next;
  logic [WIDTH-1:0] dump_data_reg, dump_data_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dstate_reg     <= D_IDLE;
      dcnt_reg       <= '0;
      dump_valid_reg <= 1'b0;
      dump_done_reg  <= 1'b0;
      dump_idx_reg   <= '0;
      dump_data_reg  <= '0;
    end else begin
      dstate_reg     <= dstate_next;
      dcnt_reg       <= dcnt_next;
      dump_valid_reg <= dump_valid_next;
      dump_done_reg  <= dump_done_next;
      dump_idx_reg   <= dump_idx_next;
      dump_data_reg  <= dump_data_next;
    end
  end

  // Dump beats sample the array before this edge's writes land (no bypass).
  always_comb begin
    dstate_next     = dstate_reg;
    dcnt_next       = dcnt_reg;
    dump_valid_next = 1'b0;
    dump_done_next  = 1'b0;
    dump_idx_next   = dump_idx_reg;
    dump_data_next  = dump_data_reg;
    if (!run) begin
      dstate_next = D_IDLE;
    end else begin
      case (dstate_reg)
        D_IDLE: begin
          if (dump_req) begin
            dstate_next = D_ACTIVE;
            dcnt_next   = '0;
          end
        end
        D_ACTIVE: begin
          dump_valid_next = 1'b1;
          dump_idx_next   = dcnt_reg;
          dump_data_next  = mem[dcnt_reg];
          dcnt_next       = dcnt_reg + AW'(1);
          if (dcnt_reg == AW'(DEPTH - 1)) begin
            dump_done_next = 1'b1;
            dstate_next    = D_IDLE;
          end
        end
        default: dstate_next = D_IDLE;
      endcase
    end
  end

  assign dump_valid = dump_valid_reg;
  assign dump_done  = dump_done_reg;
  assign dump_idx   = dump_idx_reg;
  assign dump_data  = dump_data_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a 32x32 bypassed instance and a 16x16 four-read non-bypassed
// instance, each checked every cycle against a behavioural model plus literal checks.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  // Instance A: WIDTH 32, DEPTH 32, NREAD 2, BYPASS 1, ZERO_REG 1
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        wr0_en = 1'b0, wr1_en = 1'b0;
  logic [4:0]  wr0_addr = '0, wr1_addr = '0;
  logic [31:0] wr0_data = '0, wr1_data = '0;
  logic        ready, dump_req = 1'b0, dump_valid, dump_done;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  // Instance B: WIDTH 16, DEPTH 16, NREAD 4, BYPASS 0, ZERO_REG 1
  logic [15:0] b_rd_addr = '0;
  logic [63:0] b_rd_data;
  logic        b_wr0_en = 1'b0, b_wr1_en = 1'b0;
  logic [3:0]  b_wr0_addr = '0, b_wr1_addr = '0;
  logic [15:0] b_wr0_data = '0, b_wr1_data = '0;
  logic        b_ready, b_dump_req = 1'b0, b_dump_valid, b_dump_done;
  logic [3:0]  b_dump_idx;
  logic [15:0] b_dump_data;

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .ready(ready), .dump_req(dump_req), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(16), .NREAD(4), .BYPASS(0), .ZERO_REG(1)) u_b (
    .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .wr0_en(b_wr0_en), .wr0_addr(b_wr0_addr), .wr0_data(b_wr0_data),
    .wr1_en(b_wr1_en), .wr1_addr(b_wr1_addr), .wr1_data(b_wr1_data),
    .ready(b_ready), .dump_req(b_dump_req), .dump_valid(b_dump_valid),
    .dump_idx(b_dump_idx), .dump_data(b_dump_data), .dump_done(b_dump_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural models ----------------
  int          a_edges = 0;      // edges with reset high since last reset
  logic [31:0] a_mem [32];
  int          a_beat = -1;      // next beat number to be registered, -1 when idle
  logic        e_dv = 0, e_done = 0;
  logic [4:0]  e_idx = 0;
  logic [31:0] e_data = 0;
  int          b_edges = 0;
  logic [15:0] b_mem [16];
  logic        started = 0;
  logic        a_ready, b_ready_m;

  assign a_ready   = (a_edges >= 32);
  assign b_ready_m = (b_edges >= 16);

  always @(posedge clk) begin
    started <= 1'b1;
    if (!reset) begin
      a_edges <= 0;
      b_edges <= 0;
      for (int i = 0; i < 32; i++) a_mem[i] <= '0;
      for (int i = 0; i < 16; i++) b_mem[i] <= '0;
      a_beat <= -1;
      e_dv <= 0; e_done <= 0; e_idx <= 0; e_data <= 0;
    end else begin
      if (a_edges < 32) a_edges <= a_edges + 1;
      if (b_edges < 16) b_edges <= b_edges + 1;
      e_dv   <= 0;
      e_done <= 0;
      if (a_ready) begin
        if (wr0_en && wr0_addr != 0) a_mem[wr0_addr] <= wr0_data;
        if (wr1_en && wr1_addr != 0) a_mem[wr1_addr] <= wr1_data;
        if (a_beat >= 0) begin
          e_dv   <= 1;
          e_idx  <= 5'(a_beat);
          e_data <= a_mem[a_beat];
          e_done <= (a_beat == 31);
          a_beat <= (a_beat == 31) ? -1 : a_beat + 1;
        end else if (dump_req) begin
          a_beat <= 0;
        end
      end else begin
        a_beat <= -1;
      end
      if (b_ready_m && b_wr0_en && b_wr0_addr != 0) b_mem[b_wr0_addr] <= b_wr0_data;
    end
  end

  function automatic logic [31:0] a_exp_rd(input logic [4:0] ad);
    if (!a_ready || ad == 0) return '0;
    if (wr1_en && wr1_addr == ad) return wr1_data;
    if (wr0_en && wr0_addr == ad) return wr0_data;
    return a_mem[ad];
  endfunction

  function automatic logic [15:0] b_exp_rd(input logic [3:0] ad);
    if (!b_ready_m || ad == 0) return '0;
    return b_mem[ad];
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("a_ready", ready, a_ready);
      for (int k = 0; k < 2; k++)
        chk($sformatf("a_rd%0d", k), rd_data[k*32 +: 32], a_exp_rd(rd_addr[k*5 +: 5]));
      chk("a_dump_valid", dump_valid, e_dv);
      chk("a_dump_done", dump_done, e_done);
      chk("a_dump_idx", dump_idx, e_idx);
      chk("a_dump_data", dump_data, e_data);
      chk("b_ready", b_ready, b_ready_m);
      for (int k = 0; k < 4; k++)
        chk($sformatf("b_rd%0d", k), b_rd_data[k*16 +: 16], b_exp_rd(b_rd_addr[k*4 +: 4]));
      chk("b_dump_valid", b_dump_valid, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset sweep, with a write attempted mid-sweep
    repeat (3) step();
    chk("lit_ready_in_reset", ready, 1'b0);
    reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      if (i == 10) begin
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1234;
      end
      step();
      wr0_en = 0;
      if (i == 16) chk("lit_b_ready_16", b_ready, 1'b1);
      if (i == 31) chk("lit_ready_31", ready, 1'b0);
      if (i == 32) chk("lit_ready_32", ready, 1'b1);
    end
    rd_addr[4:0] = 5;
    #1 chk("lit_r5_after_sweep", rd_data[31:0], 32'h0);
    $display("sweep: ready after 32 edges, r5=%h", rd_data[31:0]);

    // Dual write, same address
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'hAAAA0000;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h5555FFFF;
    step();
    wr0_en = 0; wr1_en = 0;
    rd_addr[4:0] = 7;
    #1 chk("lit_r7_dual", rd_data[31:0], 32'h5555FFFF);
    $display("dual write: r7=%h", rd_data[31:0]);
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFFFFFF;
    rd_addr[9:5] = 0;
    #1 chk("lit_r0_during_write", rd_data[63:32], 32'h0);
    step();
    wr0_en = 0;
    #1 chk("lit_r0_after_write", rd_data[63:32], 32'h0);
    $display("zero reg: r0=%h", rd_data[63:32]);

    // Bypass on A, none on B
    rd_addr[4:0] = 9;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'hDEADBEEF;
    #1 chk("lit_bypass_r9", rd_data[31:0], 32'hDEADBEEF);
    $display("bypass: r9 same cycle=%h", rd_data[31:0]);
    b_rd_addr[3:0] = 9;
    b_wr0_en = 1; b_wr0_addr = 9; b_wr0_data = 16'hBEEF;
    #1 chk("lit_b_nobypass_old", b_rd_data[15:0], 16'h0);
    step();
    wr1_en = 0; b_wr0_en = 0;
    #1 chk("lit_b_nobypass_new", b_rd_data[15:0], 16'hBEEF);
    $display("no bypass: r9 next cycle=%h", b_rd_data[15:0]);

    // Multi-port read on B
    for (int n = 0; n < 16; n++) begin
      b_wr0_en = 1; b_wr0_addr = 4'(n); b_wr0_data = 16'(n * 16'h0101);
      step();
    end
    b_wr0_en = 0;
    b_rd_addr = {4'd8, 4'd0, 4'd15, 4'd3};
    #1;
    chk("lit_b_p0", b_rd_data[15:0], 16'h0303);
    chk("lit_b_p1", b_rd_data[31:16], 16'h0F0F);
    chk("lit_b_p2", b_rd_data[47:32], 16'h0000);
    chk("lit_b_p3", b_rd_data[63:48], 16'h0808);
    $display("multiport: %h %h %h %h", b_rd_data[15:0], b_rd_data[31:16], b_rd_data[47:32], b_rd_data[63:48]);

    // Dump with a stray request and a write during the dump
    for (int n = 1; n < 32; n++) begin
      wr0_en = 1; wr0_addr = 5'(n); wr0_data = 32'(n);
      step();
    end
    wr0_en = 0;
    dump_req = 1;
    step();
    dump_req = 0;
    for (int b = 0; b < 32; b++) begin
      step();
      wr0_en = 0; dump_req = 0;
      $display("dump beat: valid=%0b idx=%0d data=%h done=%0b", dump_valid, dump_idx, dump_data, dump_done);
      if (b == 0) begin
        chk("lit_beat0_valid", dump_valid, 1'b1);
        chk("lit_beat0_idx", dump_idx, 5'd0);
      end
      if (b == 3) dump_req = 1;
      if (b == 5) begin
        wr0_en = 1; wr0_addr = 20; wr0_data = 32'h99;
      end
      if (b == 10) chk("lit_beat10_data", dump_data, 32'd10);
      if (b == 20) chk("lit_beat20_data", dump_data, 32'h99);
      if (b == 30) chk("lit_beat30_done", dump_done, 1'b0);
      if (b == 31) begin
        chk("lit_beat31_done", dump_done, 1'b1);
        chk("lit_beat31_data", dump_data, 32'd31);
      end
    end
    step();
    chk("lit_after_dump_valid", dump_valid, 1'b0);
    chk("lit_after_dump_idx", dump_idx, 5'd31);
    repeat (3) step();
    chk("lit_no_second_dump", dump_valid, 1'b0);

    // Reset in the middle of a dump
    dump_req = 1;
    step();
    dump_req = 0;
    for (int b = 0; b <= 12; b++) step();
    chk("lit_mid_idx12", dump_idx, 5'd12);
    reset = 0;
    step();
    chk("lit_abort_valid", dump_valid, 1'b0);
    chk("lit_abort_done", dump_done, 1'b0);
    chk("lit_abort_ready", ready, 1'b0);
    $display("reset mid-dump: valid=%0b done=%0b ready=%0b", dump_valid, dump_done, ready);
    reset = 1;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 31) chk("lit_resweep_31", ready, 1'b0);
      if (i == 32) chk("lit_resweep_32", ready, 1'b1);
    end
    rd_addr[4:0] = 20;
    #1 chk("lit_r20_cleared", rd_data[31:0], 32'h0);
    $display("resweep: ready=%0b r20=%h", ready, rd_data[31:0]);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
